controle_magnetron_param: RTL
=============================

CONTROLE_MAGNETRON_PARAM -- requirements
Module: controle_magnetron_param

Interface
REQ-001 Parameter TIME_W, default 8, width of the remaining-time counter in seconds.
REQ-002 Parameter TICK_DIV, default 4, clock cycles per one-second tick, TICK_DIV >= 2.
REQ-003 Parameter POWER_LEVELS, default 4, number of power settings, power of two, >= 2.
REQ-004 Parameter PWM_PERIOD, default 8, magnetron duty-cycle period in clocks; SHALL be a multiple of POWER_LEVELS.
REQ-005 Derived PWR_W = clog2(POWER_LEVELS).
REQ-006 Port clk  input  1  single system clock; all state changes on rising edge.
REQ-007 Port reset  input  1  asynchronous, active-high reset.
REQ-008 Port starn  input  1  start request, active low, level sampled each clock.
REQ-009 Port stopn  input  1  stop/pause request, active low.
REQ-010 Port clearn  input  1  cancel and clear time, active low.
REQ-011 Port door_closed  input  1  1 = door closed (interlock).
REQ-012 Port load  input  1  one-cycle strobe capturing load_time.
REQ-013 Port load_time  input  TIME_W  cook time in seconds.
REQ-014 Port power_sel  input  PWR_W  power level, 0 = lowest, POWER_LEVELS-1 = full.
REQ-015 Port mag_on  output  1  magnetron enable.
REQ-016 Port time_left  output  TIME_W  remaining seconds (registered).
REQ-017 Port state  output  2  IDLE=0, COOK=1, PAUSE=2, DONE=3 (registered).
REQ-018 Port done  output  1  one-cycle pulse on entry to DONE (registered).

Function
REQ-019 Event priority each cycle SHALL be: clearn=0 > (door_closed=0 or stopn=0) > starn=0 > load.
REQ-020 IDLE: load=1 SHALL set time_left=load_time next cycle; load in any other state SHALL be ignored.
REQ-021 IDLE -> COOK when starn=0, door_closed=1, stopn=1, time_left!=0; tick prescaler and PWM counter SHALL clear to 0 and power_sel SHALL be latched.
REQ-022 IDLE with starn=0 and (door open or time_left=0) SHALL remain IDLE.
REQ-023 COOK: prescaler counts 0..TICK_DIV-1 and wraps; on wrap time_left SHALL decrement by 1.
REQ-024 COOK: wrap with time_left=1 SHALL set time_left=0, enter DONE, assert done for exactly one cycle.
REQ-025 COOK -> PAUSE on stopn=0 or door_closed=0; time_left and prescaler SHALL hold.
REQ-026 PAUSE -> COOK on starn=0 with door_closed=1 and stopn=1; prescaler resumes from held value, PWM counter clears, power_sel re-latched.
REQ-027 clearn=0 in COOK, PAUSE or DONE SHALL enter IDLE with time_left=0.
REQ-028 DONE -> IDLE when clearn=0 or door_closed=0; starn in DONE SHALL be ignored.
REQ-029 PWM counter SHALL count 0..PWM_PERIOD-1 and wrap, only in COOK.
REQ-030 mag_on = (state==COOK) and door_closed and (pwm_cnt < (pwr_latched+1)*PWM_PERIOD/POWER_LEVELS), combinational from registers and door_closed, so door opening drops mag_on in the same cycle.
REQ-031 time_left SHALL never underflow below 0.

Reset
REQ-032 reset=1 SHALL immediately force state=IDLE, time_left=0, done=0, mag_on=0, prescaler=0, PWM counter=0, latched power=0, regardless of clk.
REQ-033 Reset asserted mid-COOK SHALL abort cooking; after release the block SHALL wait in IDLE for a new load and start.

Verification
REQ-034 Reset pulse during COOK -> mag_on=0 without a clock edge; after release state=0, time_left=0.
REQ-035 Defaults, load_time=3, power_sel=3, start with door closed -> mag_on=1 for 12 consecutive cycles, time_left 3->2->1->0 every 4 cycles, done pulses once, state=3, then mag_on=0.
REQ-036 power_sel=0, load_time=4 -> mag_on high 2 of every 8 cycles during COOK, 16 cycles total COOK.
REQ-037 Door opened at time_left=2 -> mag_on=0 same cycle, state=2, time_left holds 2; door closed + starn=0 -> COOK resumes, DONE after remaining ticks.
REQ-038 starn=0 with door_closed=0, or with time_left=0 -> state stays 0, mag_on=0.
REQ-039 clearn=0 and starn=0 same cycle in PAUSE -> state=0, time_left=0; load ignored while in COOK.

Source files
------------

// File: rtl/controle_magnetron_param.sv
// Microwave magnetron controller: cook-time countdown with pause/resume,
// door interlock and duty-cycle power control of the magnetron enable.
module controle_magnetron_param #(
    parameter int TIME_W       = 8,
    parameter int TICK_DIV     = 4,
    parameter int POWER_LEVELS = 4,
    parameter int PWM_PERIOD   = 8,
    localparam int PWR_W       = $clog2(POWER_LEVELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              starn,
    input  logic              stopn,
    input  logic              clearn,
    input  logic              door_closed,
    input  logic              load,
    input  logic [TIME_W-1:0] load_time,
    input  logic [PWR_W-1:0]  power_sel,
    output logic              mag_on,
    output logic [TIME_W-1:0] time_left,
    output logic [1:0]        state,
    output logic              done
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int PWM_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int CMP_W = PWM_W + 1;
    localparam int STEP  = PWM_PERIOD / POWER_LEVELS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [PWM_W-1:0]   pwm_q, pwm_d;
    logic [PWR_W-1:0]   pwr_q, pwr_d;
    logic               done_q, done_d;
    logic               halt;
    logic [CMP_W-1:0]   thresh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            time_q  <= '0;
            presc_q <= '0;
            pwm_q   <= '0;
            pwr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            pwr_q   <= pwr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        pwm_d   = pwm_q;
        pwr_d   = pwr_q;
        done_d  = 1'b0;
        halt    = ~door_closed | ~stopn;

        // Each branch chain encodes the event priority: clear, then halt, then start, then load.
        unique case (state_q)
            IDLE: begin
                if (!clearn) begin
                    time_d = '0;
                end else if (!halt) begin
                    if (!starn) begin
                        if (time_q != '0) begin
                            state_d = COOK;
                            presc_d = '0;
                            pwm_d   = '0;
                            pwr_d   = power_sel;
                        end
                    end else if (load) begin
                        time_d = load_time;
                    end
                end
            end
            COOK: begin
                if (!clearn) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (halt) begin
                    state_d = PAUSE;
                end else begin
                    pwm_d = (pwm_q == PWM_W'(PWM_PERIOD - 1)) ? '0 : pwm_q + PWM_W'(1);
                    if (presc_q == PRE_W'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        if (time_q <= TIME_W'(1)) begin
                            time_d  = '0;
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            time_d = time_q - TIME_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + PRE_W'(1);
                    end
                end
            end
            PAUSE: begin
                if (!clearn) begin
                    state_d = IDLE;
                    time_d  = '0;
                end else if (!halt && !starn) begin
                    // Prescaler keeps its held phase so a paused second is not lost.
                    state_d = COOK;
                    pwm_d   = '0;
                    pwr_d   = power_sel;
                end
            end
            DONE: begin
                if (!clearn || !door_closed) begin
                    state_d = IDLE;
                    time_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        thresh    = (CMP_W'(pwr_q) + CMP_W'(1)) * CMP_W'(STEP);
        mag_on    = (state_q == COOK) && door_closed && ({1'b0, pwm_q} < thresh);
        time_left = time_q;
        state     = state_q;
        done      = done_q;
    end

endmodule
